// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared definitions for the DMA read sequencer: control register
//               indices, CONTROL/STATUS bit positions and the sequencer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  // Control register indices (ctl_address)
  localparam logic [2:0] REG_CONTROL = 3'd0;
  localparam logic [2:0] REG_LENGTH  = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_COUNT   = 3'd3;
  localparam logic [2:0] REG_ADDR    = 3'd4;

  // CONTROL bits (self-clearing strobes)
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  // STATUS bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ABORTED_BIT = 2;
  localparam int STAT_ERR_BIT     = 3;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_read_sequencer_if
// Description : Bundles the three buses of the DMA read sequencer:
//               - control slave  : ctl_address/write/writedata/read/readdata/
//                                  waitrequest (CPU side)
//               - read master    : m_address/read/readdata/readdatavalid/
//                                  waitrequest (data source side)
//               - output stream  : out_data/valid/ready (consumer side)
//               modport master : the sequencer's view
//               modport slave  : the surrounding system's view
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_read_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 1
) ();

  // Control slave
  logic [2:0]        ctl_address;
  logic              ctl_write;
  logic [31:0]       ctl_writedata;
  logic              ctl_read;
  logic [31:0]       ctl_readdata;
  logic              ctl_waitrequest;

  // Avalon-MM pipelined read master
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              m_waitrequest;

  // Output stream
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  ctl_address, ctl_write, ctl_writedata, ctl_read,
    output ctl_readdata, ctl_waitrequest,
    output m_address, m_read,
    input  m_readdata, m_readdatavalid, m_waitrequest,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    output ctl_address, ctl_write, ctl_writedata, ctl_read,
    input  ctl_readdata, ctl_waitrequest,
    input  m_address, m_read,
    output m_readdata, m_readdatavalid, m_waitrequest,
    input  out_data, out_valid,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head word is
//               presented on pop_data whenever empty is low; a word pushed in
//               cycle N is visible at the head in cycle N+1.
//               Ports: clk, reset (sync, active-high), push/push_data,
//                      pop/pop_data, count, full, empty.
//               A push while full is only accepted together with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                PTR_W        = $clog2(DEPTH);
  localparam logic [PTR_W:0]    C_FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_pop_en;
  logic              w_push_en;

  assign w_pop_en  = pop && !empty;
  // When full, the slot freed by a same-cycle pop is the one being written.
  assign w_push_en = push && (!full || w_pop_en);

  assign full     = (r_count == C_FULL_COUNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // Storage is not reset; the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow is a bug in the producer's flow control.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full && !pop));
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dma_read_sequencer
// Description : Control-programmed Avalon-MM pipelined read master. Software
//               programs ADDR and LENGTH and writes START; the block issues
//               LENGTH reads to a fixed address, limits outstanding reads by
//               the free space in its return FIFO, and streams returned words
//               out over ready/valid.
//               Ports: clk, reset (sync, active-high),
//                      bus (dma_read_sequencer_if.master): control slave,
//                      read master and output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_read_sequencer
  import dma_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int ADDR_W     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_read_sequencer_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  dma_state_e         r_state;
  dma_state_e         w_state_next;

  logic [LEN_W-1:0]   r_length;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_issued;
  logic [LEN_W-1:0]   r_received;
  logic [LEN_W-1:0]   r_outstanding;
  logic               r_done;
  logic               r_aborted;
  logic               r_err;
  logic [31:0]        r_readdata;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic               w_busy;
  logic               w_wr_ctrl;
  logic               w_start;
  logic               w_abort;
  logic               w_wr_length;
  logic               w_wr_status;
  logic               w_wr_addr;
  logic               w_accept;
  logic               w_ret_ok;
  logic               w_spurious;
  logic               w_m_read;
  logic               w_launch;
  logic               w_set_done;
  logic               w_set_aborted;
  logic [LEN_W:0]     w_credit_sum;
  logic               w_credit_ok;
  logic [31:0]        w_rd_mux;

  logic [DATA_W-1:0]  w_fifo_data;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_fifo_pop;
  logic               w_unused_ok;

  assign w_busy      = (r_state != IDLE);

  assign w_wr_ctrl   = bus.ctl_write && (bus.ctl_address == REG_CONTROL);
  assign w_start     = w_wr_ctrl && bus.ctl_writedata[CTRL_START_BIT];
  assign w_abort     = w_wr_ctrl && bus.ctl_writedata[CTRL_ABORT_BIT];
  assign w_wr_length = bus.ctl_write && (bus.ctl_address == REG_LENGTH);
  assign w_wr_status = bus.ctl_write && (bus.ctl_address == REG_STATUS);
  assign w_wr_addr   = bus.ctl_write && (bus.ctl_address == REG_ADDR);

  assign w_accept    = w_m_read && !bus.m_waitrequest;
  // A return with nothing outstanding cannot belong to this transfer.
  assign w_ret_ok    = bus.m_readdatavalid && (r_outstanding != '0);
  assign w_spurious  = bus.m_readdatavalid && (r_outstanding == '0);

  // Every outstanding read already owns a FIFO slot, so the sum of in-flight
  // and buffered words may never exceed the FIFO depth.
  assign w_credit_sum = {1'b0, r_outstanding} + (LEN_W + 1)'(w_fifo_count);
  assign w_credit_ok  = (w_credit_sum < (LEN_W + 1)'(FIFO_DEPTH));

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_m_read      = 1'b0;
    w_launch      = 1'b0;
    w_set_done    = 1'b0;
    w_set_aborted = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (r_length != '0) begin
            w_state_next = RUN;
            w_launch     = 1'b1;
          end else begin
            w_set_done   = 1'b1;
          end
        end
      end
      RUN: begin
        w_m_read = (r_issued < r_length) && w_credit_ok;
        if (r_received == r_length) begin
          w_state_next = IDLE;
          w_set_done   = 1'b1;
        end else if (w_abort) begin
          // The read presented this cycle may still be accepted.
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_outstanding == '0) begin
          w_state_next  = IDLE;
          w_set_aborted = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration, status and transfer counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_length      <= '0;
      r_addr        <= '0;
      r_issued      <= '0;
      r_received    <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_wr_length && !w_busy) begin
        r_length <= bus.ctl_writedata[LEN_W-1:0];
      end
      if (w_wr_addr && !w_busy) begin
        r_addr <= bus.ctl_writedata[ADDR_W-1:0];
      end

      // Sticky flags: write-1-to-clear, then launch clear, then set (set wins).
      if (w_wr_status && bus.ctl_writedata[STAT_DONE_BIT]) begin
        r_done <= 1'b0;
      end
      if (w_wr_status && bus.ctl_writedata[STAT_ABORTED_BIT]) begin
        r_aborted <= 1'b0;
      end
      if (w_wr_status && bus.ctl_writedata[STAT_ERR_BIT]) begin
        r_err <= 1'b0;
      end
      if (w_launch) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_set_aborted) begin
        r_aborted <= 1'b1;
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end

      if (w_launch) begin
        r_issued   <= '0;
        r_received <= '0;
      end else begin
        r_issued   <= r_issued + LEN_W'(w_accept);
        r_received <= r_received + LEN_W'(w_ret_ok);
      end

      case ({w_accept, w_ret_ok})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_outstanding <= LEN_W'(FIFO_DEPTH));
    end
  end

  // --------------------------------------------------------------------------
  // Control read path (latency 1)
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_mux = '0;
    case (bus.ctl_address)
      REG_LENGTH: w_rd_mux = 32'(r_length);
      REG_STATUS: begin
        w_rd_mux[STAT_BUSY_BIT]    = w_busy;
        w_rd_mux[STAT_DONE_BIT]    = r_done;
        w_rd_mux[STAT_ABORTED_BIT] = r_aborted;
        w_rd_mux[STAT_ERR_BIT]     = r_err;
      end
      REG_COUNT:  w_rd_mux = 32'(r_received);
      REG_ADDR:   w_rd_mux = 32'(r_addr);
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (bus.ctl_read) begin
      r_readdata <= w_rd_mux;
    end else begin
      r_readdata <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Return-data FIFO
  // --------------------------------------------------------------------------
  assign w_fifo_pop = !w_fifo_empty && bus.out_ready;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_ret_ok),
    .push_data (bus.m_readdata),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_data),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ctl_readdata    = r_readdata;
  assign bus.ctl_waitrequest = 1'b0;
  assign bus.m_address       = r_addr;
  assign bus.m_read          = w_m_read;
  assign bus.out_data        = w_fifo_data;
  assign bus.out_valid       = !w_fifo_empty;

  // Upper write-data bits and the FIFO full flag are intentionally unused.
  assign w_unused_ok = ^{bus.ctl_writedata, w_fifo_full};

endmodule
`default_nettype wire

// File: doc/dma_read_sequencer.md
Name: dma_read_sequencer

Overview:
- Control-programmed Avalon-MM pipelined read master that sequences word reads from a streaming data source slave.
- The slave has an address, read, readdata, readdatavalid and waitrequest interface.
- Software writes ADDR, LENGTH and START through a control slave. The block then issues LENGTH reads, tracks outstanding reads with credits, and buffers returned words in an internal FIFO drained by a ready/valid stream.
- Sits between the CPU-side control bus, the data source slave, and the downstream sample consumer.

Parameters:
- DATA_W, 32, data word width (master readdata and stream data).
- LEN_W, 16, width of the LENGTH and COUNT registers.
- ADDR_W, 1, width of m_address.
- FIFO_DEPTH, 8, depth of the return-data FIFO (power of two, at least 2); also the credit limit.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- ctl_address  in  3  control register index.
- ctl_write  in  1  control write strobe.
- ctl_writedata  in  32  control write data.
- ctl_read  in  1  control read strobe.
- ctl_readdata  out  32  control read data, fixed read latency 1.
- ctl_waitrequest  out  1  always 0.
- m_address  out  ADDR_W  read address.
- m_read  out  1  read request.
- m_readdata  in  DATA_W  returned data.
- m_readdatavalid  in  1  return strobe.
- m_waitrequest  in  1  slave stall.
- out_data  out  DATA_W  stream data (FIFO head).
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - state=IDLE.
  - All registers 0; issued, received and outstanding counters 0.
  - FIFO empty.
  - m_read=0, m_address=0, out_valid=0, ctl_readdata=0, ctl_waitrequest=0.
- Reset mid-transfer aborts immediately. No drain. The FIFO is flushed.
- Register map:
  - 0 CONTROL: write-only. Bit0 START, bit1 ABORT, both self-clearing. Reads return 0.
  - 1 LENGTH: R/W, LEN_W bits, zero-extended on read.
  - 2 STATUS: bit0 BUSY (read-only). Bit1 DONE, bit2 ABORTED, bit3 ERR, all sticky and write-1-to-clear.
  - 3 COUNT: read-only, words received in the current or last transfer.
  - 4 ADDR: R/W, ADDR_W bits; drives m_address.
  - Other addresses: reads return 0, writes are ignored.
- Control write semantics:
  - Writes to LENGTH and ADDR while BUSY are ignored.
  - ctl_readdata is registered: it reflects the register value in the cycle after ctl_read.
- State machine IDLE / RUN / DRAIN:
  - IDLE to RUN: START written with LENGTH!=0. Clears COUNT, issued and DONE/ABORTED; RUN is entered next cycle, and m_read may assert that same next cycle.
  - START with LENGTH==0: set DONE in the next cycle and stay in IDLE.
  - START while BUSY: ignored.
  - RUN issue rule: m_read=1 iff issued<LENGTH and outstanding+fifo_count<FIFO_DEPTH (credit check).
  - A read is accepted on m_read && !m_waitrequest: issued++ and outstanding++.
  - m_read and m_address hold steady while m_waitrequest=1.
  - RUN to IDLE: received==LENGTH. Set DONE.
  - ABORT in RUN: m_read deasserts next cycle (an accept in the abort cycle counts), then DRAIN. ABORT in IDLE is ignored.
  - DRAIN to IDLE: outstanding==0. Set ABORTED. Words returned during DRAIN are still pushed to the FIFO and counted.
  - BUSY = (state!=IDLE).
- Return path:
  - m_readdatavalid pushes m_readdata into the FIFO, with outstanding-- and received++ (COUNT).
  - Accept and return in the same cycle leave outstanding unchanged.
  - m_readdatavalid with outstanding==0 is discarded (no push, no count) and sets ERR.
- FIFO:
  - First-word-fall-through: a word pushed at cycle N has out_valid=1 at N+1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full or empty is legal; the count is unchanged when full.
  - The credit rule guarantees no overflow; an overflow attempt is an assertion failure in simulation.
- Counter widths: issued, received and outstanding are LEN_W bits; outstanding never exceeds FIFO_DEPTH.

Decomposition:
- Shared package dma_pkg:
  - Register index constants (REG_CONTROL=0, REG_LENGTH=1, REG_STATUS=2, REG_COUNT=3, REG_ADDR=4).
  - STATUS and CONTROL bit positions.
  - State enum {IDLE, RUN, DRAIN}.
- One sub-module: sync_fifo_fwft (parameters DATA_W and DEPTH; outputs count, full, empty). It is reusable by other DMA blocks.

Test Plan:
- ADDR=1, LENGTH=4, START; slave never stalls, latency 1 -> four m_read accepts with m_address=1; out_data 1,2,3,4 in order; COUNT=4; STATUS=0x2.
- LENGTH=20, out_ready=0 -> exactly 8 reads accepted, then m_read stays 0. Raise out_ready -> the remaining 12 are issued; 20 words received; no FIFO overflow.
- m_waitrequest=1 for 3 cycles on the first read -> m_read and m_address stable for those cycles; only one accept is counted.
- LENGTH=16, ABORT after 5 accepts with 3 outstanding -> no further m_read; DRAIN until 3 returns; STATUS=0x4; COUNT=5.
- LENGTH=0 with START -> BUSY never set; DONE=1 next cycle; no m_read. Spurious m_readdatavalid in IDLE -> ERR=1; FIFO still empty.
- reset asserted mid-RUN with 2 outstanding -> next cycle state IDLE, m_read=0, out_valid=0, all registers 0.
